// File: rtl/uart_rx_byte.sv
// uart_rx_byte: standalone 8N1 UART receiver for the fabric command/debug path.
// The rxd line is double-registered, then oversampled OVERSAMPLE times per bit.
// Each received byte lands in a single-entry valid/ready holding register.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   rxd         asynchronous serial input, idle high
//   rx_data     received byte, valid while rx_valid=1
//   rx_valid    byte available; held until accepted
//   rx_ready    consumer accepts the byte when rx_valid && rx_ready
//   rx_busy     high from start-bit detect until the receiver is back in IDLE
//   framing_err one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte completed while the holding register was occupied
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned DIV         = CLK_FREQ_HZ / (BAUD * OVERSAMPLE)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       framing_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);

  logic          sync1_q;
  logic          rxs_q;
  state_e        state_q,      state_d;
  logic [TW-1:0] tick_cnt_q,   tick_cnt_d;
  logic [SW-1:0] sample_cnt_q, sample_cnt_d;
  logic [2:0]    bit_idx_q,    bit_idx_d;
  logic [7:0]    shift_q,      shift_d;
  logic          done_q,       done_d;
  logic          stop_ok_q,    stop_ok_d;
  logic          armed_q,      armed_d;
  logic [7:0]    rx_data_q,    rx_data_d;
  logic          rx_valid_q,   rx_valid_d;
  logic          ferr_q,       ferr_d;
  logic          ovr_q,        ovr_d;
  logic          tick;

  assign tick        = (tick_cnt_q == TICK_LAST);
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = (state_q != S_IDLE);
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick ? '0 : tick_cnt_q + TW'(1);
    sample_cnt_d = sample_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    done_d       = 1'b0;
    stop_ok_d    = stop_ok_q;
    // After reset a start bit is only accepted once the line has been seen idle.
    armed_d      = armed_q | rxs_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q & ~rx_ready;
    ferr_d       = 1'b0;
    ovr_d        = 1'b0;

    // Delivery is resolved one cycle after the stop sample, so a same-cycle
    // accept frees the holding register for the new byte.
    if (done_q) begin
      if (stop_ok_q) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_d  = shift_q;
          rx_valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && !rxs_q) begin
          state_d      = S_START;
          tick_cnt_d   = '0;
          sample_cnt_d = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (sample_cnt_q == HALF_LAST) begin
            sample_cnt_d = '0;
            bit_idx_d    = '0;
            state_d      = rxs_q ? S_IDLE : S_DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (sample_cnt_q == BIT_LAST) begin
            sample_cnt_d = '0;
            shift_d      = {rxs_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (sample_cnt_q == BIT_LAST) begin
            // IDLE is re-entered mid stop bit so a following start bit is caught.
            sample_cnt_d = '0;
            done_d       = 1'b1;
            stop_ok_d    = rxs_q;
            state_d      = rxs_q ? S_IDLE : S_BREAK;
          end else begin
            sample_cnt_d = sample_cnt_q + SW'(1);
          end
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      rxs_q        <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      sample_cnt_q <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      done_q       <= 1'b0;
      stop_ok_q    <= 1'b0;
      armed_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      ferr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      sync1_q      <= rxd;
      rxs_q        <= sync1_q;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      done_q       <= done_d;
      stop_ok_q    <= stop_ok_d;
      armed_q      <= armed_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      ferr_q       <= ferr_d;
      ovr_q        <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte. The receiver runs at a fast line rate
// (4 clocks per tick, 64 clocks per bit) so that many frames fit in a short run.
module tb_uart_rx_byte;

  localparam int CLK_HZ = 100000000;
  localparam int BAUD   = 1562500;
  localparam int OS     = 16;
  localparam int DIV    = CLK_HZ / (BAUD * OS);
  localparam int BIT    = OS * DIV;
  // Edge (relative to the edge after which rxd fell) at which rx_valid rises.
  localparam int LAT    = 4 + (OS / 2 + 9 * OS) * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_busy;
  logic       framing_err;
  logic       overrun;

  uart_rx_byte #(
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .rx_busy    (rx_busy),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  ev_t        evq[$];
  int         n = 0;
  int         n_cmp = 0;
  int         n_bad = 0;

  // reference model state
  bit         m_valid;
  logic [7:0] m_data;
  bit         exp_fe, exp_ov;
  bit         busy_chk = 1'b1;
  int         busy_lo = 0, busy_hi = 0;

  // observation counters
  int         rises, vcyc, fe_cnt, ov_cnt, busy_cyc, rise_n;
  logic [7:0] got[$];
  bit         prev_valid = 1'b0;
  bit         rnd_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, n, act, exp);
    end
  endtask

  // Model update on each edge, comparison on the following falling edge.
  initial begin
    bit r, rs, nv;
    ev_t ev;
    forever begin
      @(posedge clk);
      n++;
      r  = rx_ready;
      rs = reset;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (rs) begin
        m_valid = 1'b0;
        m_data  = 8'h00;
        evq.delete();
      end else begin
        nv = m_valid && !r;
        if (evq.size() > 0 && evq[0].due == n) begin
          ev = evq.pop_front();
          if (!ev.ok) exp_fe = 1'b1;
          else if (!m_valid || r) begin
            m_data = ev.b;
            nv     = 1'b1;
          end else exp_ov = 1'b1;
        end
        m_valid = nv;
      end
      @(negedge clk);
      chk("rx_valid", rx_valid, m_valid);
      chk("rx_data", rx_data, m_data);
      chk("framing_err", framing_err, exp_fe);
      chk("overrun", overrun, exp_ov);
      if (busy_chk) chk("rx_busy", rx_busy, (n >= busy_lo && n < busy_hi));
      if (rx_valid === 1'b1 && !prev_valid) begin
        rises++;
        rise_n = n;
        got.push_back(rx_data);
      end
      if (rx_valid === 1'b1) vcyc++;
      if (framing_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (rx_busy === 1'b1) busy_cyc++;
      prev_valid = (rx_valid === 1'b1);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready) rx_ready = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  task automatic clr_counts();
    rises = 0; vcyc = 0; fe_cnt = 0; ov_cnt = 0; busy_cyc = 0; rise_n = 0;
    got.delete();
  endtask

  task automatic wait_cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Drives one frame starting at the current falling edge; returns its start cycle.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit push, output int p);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    p  = n;
    if (push) evq.push_back('{due: p + LAT, b: b, ok: stop});
    busy_lo = p + 3;
    busy_hi = p + LAT - 1;
    for (int unsigned i = 0; i < 10; i++) begin
      rxd = fr[i];
      wait_cyc(BIT);
    end
  endtask

  initial begin
    int p, p2;
    logic [9:0] fr;
    clr_counts();
    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    @(negedge clk);
    wait_cyc(2);
    chk("reset_valid", rx_valid, 1'b0);
    chk("reset_busy", rx_busy, 1'b0);
    reset = 1'b0;
    wait_cyc(10);

    // 1: single byte, never accepted
    clr_counts();
    send_frame(8'h55, 1'b1, 1'b1, p);
    chk("t1_latency", rise_n - p, 612);
    wait_cyc(2000);
    chk("t1_held_valid", rx_valid, 1'b1);
    chk("t1_data", rx_data, 8'h55);
    chk("t1_pulses", fe_cnt + ov_cnt, 0);

    // 2: back-to-back with consumer always ready
    rx_ready = 1'b1;
    wait_cyc(4);
    clr_counts();
    send_frame(8'hA3, 1'b1, 1'b1, p);
    send_frame(8'h3C, 1'b1, 1'b1, p);
    wait_cyc(50);
    chk("t2_rises", rises, 2);
    chk("t2_valid_cycles", vcyc, 2);
    chk("t2_overrun", ov_cnt, 0);
    if (got.size() == 2) begin
      chk("t2_byte0", got[0], 8'hA3);
      chk("t2_byte1", got[1], 8'h3C);
    end

    // 3: overrun while holding register is occupied
    rx_ready = 1'b0;
    clr_counts();
    send_frame(8'h11, 1'b1, 1'b1, p);
    send_frame(8'h22, 1'b1, 1'b1, p2);
    chk("t3_overrun", ov_cnt, 1);
    chk("t3_data_kept", rx_data, 8'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", rx_valid, 1'b0);

    // 4: framing error, held-low break, then a good byte
    busy_chk = 1'b0;
    wait_cyc(20);
    clr_counts();
    send_frame(8'h7E, 1'b0, 1'b1, p);
    wait_cyc(20 * BIT);
    rxd = 1'b1;
    wait_cyc(2 * BIT);
    send_frame(8'h81, 1'b1, 1'b1, p);
    wait_cyc(20);
    chk("t4_ferr_count", fe_cnt, 1);
    chk("t4_rises", rises, 1);
    if (got.size() == 1) chk("t4_byte", got[0], 8'h81);

    // 5: short glitch on the line
    clr_counts();
    rxd = 1'b0;
    wait_cyc(12);
    rxd = 1'b1;
    wait_cyc(100);
    chk("t5_busy_cycles", busy_cyc, 32);
    chk("t5_rises", rises, 0);
    chk("t5_pulses", fe_cnt + ov_cnt, 0);

    // 6: reset in the middle of bit 4
    clr_counts();
    fr = {1'b1, 8'hF0, 1'b0};
    for (int unsigned i = 0; i < 5; i++) begin
      rxd = fr[i];
      wait_cyc(BIT);
    end
    rxd = fr[5];
    wait_cyc(BIT / 2);
    reset = 1'b1;
    rxd   = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2 * BIT);
    send_frame(8'h0F, 1'b1, 1'b1, p);
    wait_cyc(20);
    chk("t6_rises", rises, 1);
    if (got.size() == 1) chk("t6_byte", got[0], 8'h0F);

    // Randomised traffic: random bytes, gaps and consumer stalls
    busy_chk  = 1'b1;
    rnd_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, p);
      rxd = 1'b1;
      if ($urandom_range(0, 2) != 0) wait_cyc($urandom_range(1, 3 * BIT));
    end
    wait_cyc(BIT);
    rnd_ready = 1'b0;
    rx_ready  = 1'b1;
    wait_cyc(10);
    chk("rnd_queue_drained", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
